// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank write path.
//   DATA_W  : width of a bank register and of port_out
//   REQ_A/B : requester IDs (A = PicoBlaze port write, B = refresh/config engine)
//   state_t : write-transaction FSM encoding
package reg_bank_pkg;
  localparam int DATA_W = 8;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin select.
//   clk, rst  : clock, asynchronous active-high reset
//   i_req_a/b : request levels
//   i_update  : record the current winner as last served
//   o_winner  : REQ_A or REQ_B (combinational); meaningful only when a request is present
// After reset B counts as last served, so A wins the first contention.
module rr_arbiter2
  import reg_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_update,
  output logic o_winner
);

  logic r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= REQ_B;
    end else if (i_update) begin
      r_last <= o_winner;
    end
  end

  always_comb begin
    o_winner = REQ_A;
    if (i_req_a && i_req_b) begin
      o_winner = ~r_last;
    end else if (i_req_b) begin
      o_winner = REQ_B;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates requesters A and B onto the shared register bank. Each write is
// a fixed four-phase transaction IDLE -> SETUP -> STROBE -> RELEASE, where
// en is one-hot on the latched address during SETUP/STROBE and w_strobe is
// high for the STROBE cycle only.
//   clk, rst          : clock, asynchronous active-high reset
//   req_x/addr_x/data_x : requester inputs (addr/data latched when granted)
//   gnt_x             : high during SETUP and STROBE of x's transaction
//   done_x            : one-cycle pulse in RELEASE of x's transaction
//   en, w_strobe, port_out : register-bank write interface
//   busy              : FSM not in IDLE
// Optional macro REG_WRITE_ARBITER_ADDR_CHECK_EN adds output err: an
// out-of-range address suppresses w_strobe and pulses err with done_x.
module reg_write_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   data_a,
  input  logic                req_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   data_b,
  output logic                gnt_a,
  output logic                gnt_b,
  output logic                done_a,
  output logic                done_b,
  output logic [NUM_REGS-1:0] en,
  output logic                w_strobe,
  output logic [DATA_W-1:0]   port_out,
  output logic                busy
`ifdef REG_WRITE_ARBITER_ADDR_CHECK_EN
  ,
  output logic                err
`endif
);

  state_t              r_state;
  state_t              w_next;
  logic                r_winner;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                w_take;
  logic                w_winner;
  logic [NUM_REGS-1:0] w_decode;

  assign w_take = (r_state == ST_IDLE) && (req_a || req_b);

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req_a  (req_a),
    .i_req_b  (req_b),
    .i_update (w_take),
    .o_winner (w_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_winner <= REQ_A;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_winner <= w_winner;
      end
    end
  end

  // Address/data are payload only: every output that exposes them is gated
  // by the FSM state, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_addr <= (w_winner == REQ_B) ? addr_b : addr_a;
      r_data <= (w_winner == REQ_B) ? data_b : data_a;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (req_a || req_b) w_next = ST_SETUP;
      ST_SETUP:   w_next = ST_STROBE;
      ST_STROBE:  w_next = ST_RELEASE;
      ST_RELEASE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // An address with no matching register decodes to all zeros.
  always_comb begin
    w_decode = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_decode[i] = (r_addr == ADDR_W'(i));
    end
  end

`ifdef REG_WRITE_ARBITER_ADDR_CHECK_EN
  logic w_in_range;
  assign w_in_range = |w_decode;
`endif

  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    done_a   = 1'b0;
    done_b   = 1'b0;
    en       = '0;
    w_strobe = 1'b0;
    port_out = '0;
    busy     = (r_state != ST_IDLE);
`ifdef REG_WRITE_ARBITER_ADDR_CHECK_EN
    err      = 1'b0;
`endif
    case (r_state)
      ST_SETUP, ST_STROBE: begin
        gnt_a    = (r_winner == REQ_A);
        gnt_b    = (r_winner == REQ_B);
        en       = w_decode;
        port_out = r_data;
        if (r_state == ST_STROBE) begin
`ifdef REG_WRITE_ARBITER_ADDR_CHECK_EN
          w_strobe = w_in_range;
`else
          w_strobe = 1'b1;
`endif
        end
      end
      ST_RELEASE: begin
        done_a   = (r_winner == REQ_A);
        done_b   = (r_winner == REQ_B);
        port_out = r_data;
`ifdef REG_WRITE_ARBITER_ADDR_CHECK_EN
        err      = ~w_in_range;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;
  logic       clk;
  logic       rst;
  logic       req_a, req_b;
  logic [1:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b, done_a, done_b;
  logic [2:0] en;
  logic       w_strobe, busy;
  logic [7:0] port_out;
`ifdef REG_WRITE_ARBITER_ADDR_CHECK_EN
  logic       err;
`endif

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(.NUM_REGS(3), .ADDR_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .addr_a   (addr_a),
    .data_a   (data_a),
    .req_b    (req_b),
    .addr_b   (addr_b),
    .data_b   (data_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .done_a   (done_a),
    .done_b   (done_b),
    .en       (en),
    .w_strobe (w_strobe),
    .port_out (port_out),
    .busy     (busy)
`ifdef REG_WRITE_ARBITER_ADDR_CHECK_EN
    ,
    .err      (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_a = 1'b1; addr_a = 2'd1; data_a = 8'h5A;
    req_b = 1'b1; addr_b = 2'd2; data_b = 8'hB4;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if ({gnt_a, gnt_b, done_a, done_b} !== 4'b0) begin errors++; $display("FAIL rst_gnt_done got %b want 0000", {gnt_a, gnt_b, done_a, done_b}); end
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL rst_en got %b want 000", en); end
    checks++; if (port_out !== 8'h00) begin errors++; $display("FAIL rst_port got %h want 00", port_out); end
    checks++; if (w_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b want 0", w_strobe); end
    rst = 1'b0;
    step();
    checks++; if ({gnt_a, gnt_b} !== 2'b10) begin errors++; $display("FAIL first_grant got %b want 10", {gnt_a, gnt_b}); end
    checks++; if (en !== 3'b010) begin errors++; $display("FAIL first_en got %b want 010", en); end
    checks++; if (port_out !== 8'h5A) begin errors++; $display("FAIL first_port got %h want 5a", port_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", busy); end
    checks++; if (gnt_a !== 1'b0) begin errors++; $display("FAIL async_gnt_a got %b want 0", gnt_a); end
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL async_en got %b want 000", en); end
    checks++; if (port_out !== 8'h00) begin errors++; $display("FAIL async_port got %h want 00", port_out); end
    req_a = 1'b0; req_b = 1'b0;
    step();
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_rst got %b want 0", busy); end
  endtask

  task automatic test_single();
    req_a = 1'b1; addr_a = 2'd2; data_a = 8'hA5;
    step();
    checks++; if (en !== 3'b100) begin errors++; $display("FAIL single_setup_en got %b want 100", en); end
    checks++; if (port_out !== 8'hA5) begin errors++; $display("FAIL single_setup_port got %h want a5", port_out); end
    checks++; if ({gnt_a, w_strobe, busy} !== 3'b101) begin errors++; $display("FAIL single_setup_ctl got %b want 101", {gnt_a, w_strobe, busy}); end
    step();
    checks++; if (w_strobe !== 1'b1) begin errors++; $display("FAIL single_strobe got %b want 1", w_strobe); end
    checks++; if (en !== 3'b100) begin errors++; $display("FAIL single_strobe_en got %b want 100", en); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL single_early_done got %b want 0", done_a); end
    step();
    checks++; if ({done_a, done_b} !== 2'b10) begin errors++; $display("FAIL single_done got %b want 10", {done_a, done_b}); end
    checks++; if ({en, w_strobe, gnt_a} !== 5'b0) begin errors++; $display("FAIL single_release got %b want 00000", {en, w_strobe, gnt_a}); end
    checks++; if (port_out !== 8'hA5) begin errors++; $display("FAIL single_release_port got %h want a5", port_out); end
    req_a = 1'b0;
    step();
    checks++; if ({busy, done_a} !== 2'b00) begin errors++; $display("FAIL single_idle got %b want 00", {busy, done_a}); end
  endtask

  task automatic test_contention();
    int  ph;
    int  k;
    logic odd;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_a = 1'b1; addr_a = 2'd0; data_a = 8'h11;
    req_b = 1'b1; addr_b = 2'd1; data_b = 8'h33;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      ph  = (cyc - 1) % 4;
      k   = (cyc - 1) / 4;
      odd = k[0];
      checks++; if ((gnt_a & gnt_b) !== 1'b0) begin errors++; $display("FAIL cont_gnt_overlap cyc %0d got 1 want 0", cyc); end
      checks++; if (w_strobe !== (ph == 1)) begin errors++; $display("FAIL cont_strobe cyc %0d got %b want %b", cyc, w_strobe, (ph == 1)); end
      if (ph == 1) begin
        checks++; if (port_out !== (odd ? 8'h33 : 8'h11)) begin errors++; $display("FAIL cont_port cyc %0d got %h want %h", cyc, port_out, (odd ? 8'h33 : 8'h11)); end
        checks++; if (en !== (odd ? 3'b010 : 3'b001)) begin errors++; $display("FAIL cont_en cyc %0d got %b want %b", cyc, en, (odd ? 3'b010 : 3'b001)); end
        checks++; if ({gnt_a, gnt_b} !== {~odd, odd}) begin errors++; $display("FAIL cont_gnt cyc %0d got %b want %b", cyc, {gnt_a, gnt_b}, {~odd, odd}); end
      end
      if (ph == 2) begin
        checks++; if ({done_a, done_b} !== {~odd, odd}) begin errors++; $display("FAIL cont_done cyc %0d got %b want %b", cyc, {done_a, done_b}, {~odd, odd}); end
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle got %b want 0", busy); end
  endtask

  task automatic test_abort_free();
    req_b = 1'b1; addr_b = 2'd2; data_b = 8'hC3;
    step();
    checks++; if (gnt_b !== 1'b1) begin errors++; $display("FAIL abort_gnt_b got %b want 1", gnt_b); end
    req_b = 1'b0; addr_b = 2'd0; data_b = 8'h00;
    step();
    checks++; if (w_strobe !== 1'b1) begin errors++; $display("FAIL abort_strobe got %b want 1", w_strobe); end
    checks++; if (port_out !== 8'hC3) begin errors++; $display("FAIL abort_port got %h want c3", port_out); end
    checks++; if (en !== 3'b100) begin errors++; $display("FAIL abort_en got %b want 100", en); end
    step();
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL abort_done_b got %b want 1", done_b); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_midop();
    req_a = 1'b1; addr_a = 2'd1; data_a = 8'h77;
    step(); step();
    checks++; if (w_strobe !== 1'b1) begin errors++; $display("FAIL midrst_pre_strobe got %b want 1", w_strobe); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({w_strobe, busy, gnt_a} !== 3'b000) begin errors++; $display("FAIL midrst_outputs got %b want 000", {w_strobe, busy, gnt_a}); end
    req_a = 1'b0;
    step();
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %b want 0", done_a); end
    rst = 1'b0;
    step();
    checks++; if ({done_a, busy} !== 2'b00) begin errors++; $display("FAIL midrst_idle got %b want 00", {done_a, busy}); end
    req_a = 1'b1; addr_a = 2'd0; data_a = 8'h0F;
    step(); step();
    checks++; if ({w_strobe, en} !== 4'b1001) begin errors++; $display("FAIL midrst_next_strobe got %b want 1001", {w_strobe, en}); end
    checks++; if (port_out !== 8'h0F) begin errors++; $display("FAIL midrst_next_port got %h want 0f", port_out); end
    step();
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL midrst_next_done got %b want 1", done_a); end
    req_a = 1'b0;
    step();
  endtask

  task automatic test_out_of_range();
    logic exp_strobe;
`ifdef REG_WRITE_ARBITER_ADDR_CHECK_EN
    exp_strobe = 1'b0;
`else
    exp_strobe = 1'b1;
`endif
    req_a = 1'b1; addr_a = 2'd3; data_a = 8'hEE;
    step();
    checks++; if ({en, gnt_a, busy} !== 5'b00011) begin errors++; $display("FAIL oor_setup got %b want 00011", {en, gnt_a, busy}); end
    step();
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL oor_strobe_en got %b want 000", en); end
    checks++; if (w_strobe !== exp_strobe) begin errors++; $display("FAIL oor_strobe got %b want %b", w_strobe, exp_strobe); end
    step();
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL oor_done got %b want 1", done_a); end
`ifdef REG_WRITE_ARBITER_ADDR_CHECK_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err got %b want 1", err); end
`endif
    req_a = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oor_idle got %b want 0", busy); end
`ifdef REG_WRITE_ARBITER_ADDR_CHECK_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_err_clear got %b want 0", err); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    req_a = 1'b0; addr_a = '0; data_a = '0;
    req_b = 1'b0; addr_b = '0; data_b = '0;
    test_reset();
    test_single();
    test_contention();
    test_abort_free();
    test_reset_midop();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
